avm_master_ctrl: RTL

//  Parametrised Avalon-MM master sequencer; next generation of the EEPROM boot/read/write controller.

---
 rtl/avm_ctrl_pkg.sv | 37 +++
 rtl/avm_wait_timer.sv | 28 ++
 rtl/avm_master_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/avm_ctrl_pkg.sv
// Shared types and constants for the Avalon-MM master sequencer.
// Mode/state encodings, error codes and the OKAY response value.
package avm_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_BULK_RD = 2'b00,
    MODE_SWR     = 2'b01,
    MODE_SRD     = 2'b10,
    MODE_BULK_WR = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    RD    = 3'd3,
    WR    = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SLAVE   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  localparam logic [1:0] AVM_RESP_OKAY = 2'b00;

  function automatic logic is_bulk(input mode_e m);
    return (m == MODE_BULK_RD) || (m == MODE_BULK_WR);
  endfunction

  function automatic logic is_read(input mode_e m);
    return (m == MODE_BULK_RD) || (m == MODE_SRD);
  endfunction

endpackage

// File: rtl/avm_wait_timer.sv
// Waitrequest timeout counter: counts cycles while run is high,
// clears when run drops; expired flags the TO_CYC-th stalled cycle.
module avm_wait_timer #(
  parameter int TO_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign expired = run && (cnt_q == CW'(TO_CYC - 1));

endmodule

// File: rtl/avm_master_ctrl.sv
// Avalon-MM master sequencer: bulk/single read and write with beat retry.
// Define AVM_TIMEOUT_EN to abort on a waitrequest stall of TO_CYC cycles.
module avm_master_ctrl
  import avm_ctrl_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int LAW       = 8,
  parameter int MAX_RETRY = 2,
  parameter int TO_CYC    = 1024
) (
  input  logic           clk_50,
  input  logic           reset_n,
  input  logic           req_new,
  input  logic [1:0]     req_mode,
  input  logic [AW-1:0]  req_addr,
  input  logic [DW-1:0]  req_wdata,
  output logic           req_busy,
  output logic           req_done,
  output logic [DW-1:0]  req_rdata,
  output logic           err,
  output logic [1:0]     err_code,
  output logic [LAW-1:0] lram_addr,
  output logic [DW-1:0]  lram_wdata,
  output logic           lram_we,
  input  logic [DW-1:0]  lram_rdata,
  output logic [AW-1:0]  avm_addr,
  output logic           avm_read,
  output logic           avm_write,
  output logic [DW-1:0]  avm_wdata,
  input  logic [DW-1:0]  avm_rdata,
  input  logic           avm_wait,
  input  logic [1:0]     avm_resp
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  if (TO_CYC < 1) begin : g_bad_to
    $error("avm_master_ctrl: TO_CYC must be at least 1");
  end

  state_e          state_q, state_d;
  mode_e           mode_q;
  logic [AW-1:0]   base_q;
  logic [LAW-1:0]  idx_q;
  logic [RW-1:0]   retry_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   cap_q;
  logic [1:0]      resp_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic [1:0]      code_q;

  logic strobe;
  logic last;
  logic resp_ok;
  logic can_retry;
  logic to_exp;

  assign strobe    = (state_q == RD) || (state_q == WR);
  assign last      = !is_bulk(mode_q) || (idx_q == '1);
  assign resp_ok   = (resp_q == AVM_RESP_OKAY);
  assign can_retry = (retry_q < RW'(MAX_RETRY));

`ifdef AVM_TIMEOUT_EN
  avm_wait_timer #(
    .TO_CYC (TO_CYC)
  ) u_wait_timer (
    .clk     (clk_50),
    .rst_n   (reset_n),
    .run     (strobe && avm_wait),
    .expired (to_exp)
  );
`else
  // no abort path: a stalled slave is waited on indefinitely
  assign to_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_new) begin
          case (mode_e'(req_mode))
            MODE_BULK_WR: state_d = FETCH;
            MODE_SWR:     state_d = WR;
            MODE_BULK_RD: state_d = RD;
            MODE_SRD:     state_d = RD;
            default:      state_d = IDLE;
          endcase
        end
      end
      FETCH: state_d = LOAD;
      LOAD:  state_d = WR;
      RD, WR: begin
        if (!avm_wait) begin
          state_d = NEXT;
        end else if (to_exp) begin
          state_d = DONE;
        end
      end
      NEXT: begin
        // a retried write reuses the held data, no re-fetch
        if (!resp_ok) begin
          if (can_retry) begin
            state_d = is_read(mode_q) ? RD : WR;
          end else begin
            state_d = DONE;
          end
        end else if (last) begin
          state_d = DONE;
        end else begin
          state_d = (mode_q == MODE_BULK_WR) ? FETCH : RD;
        end
      end
      DONE: begin
        if (!req_new) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_BULK_RD;
      base_q  <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      resp_q  <= AVM_RESP_OKAY;
      rdata_q <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_new) begin
            mode_q  <= mode_e'(req_mode);
            base_q  <= req_addr;
            wdata_q <= req_wdata;
            idx_q   <= '0;
            retry_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
          end
        end
        FETCH: ;
        LOAD: wdata_q <= lram_rdata;
        RD, WR: begin
          if (!avm_wait) begin
            cap_q  <= avm_rdata;
            resp_q <= avm_resp;
          end else if (to_exp) begin
            err_q  <= 1'b1;
            code_q <= ERR_TIMEOUT;
          end
        end
        NEXT: begin
          if (!resp_ok) begin
            if (can_retry) begin
              retry_q <= retry_q + 1'b1;
            end else begin
              err_q  <= 1'b1;
              code_q <= ERR_SLAVE;
            end
          end else begin
            retry_q <= '0;
            if (mode_q == MODE_SRD) begin
              rdata_q <= cap_q;
            end
            if (!last) begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (!req_new) begin
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
          end
        end
        default: begin
          idx_q   <= '0;
          retry_q <= '0;
          err_q   <= 1'b0;
          code_q  <= ERR_ILLEGAL;
        end
      endcase
    end
  end

  assign req_busy   = (state_q == FETCH) || (state_q == LOAD) ||
                      strobe || (state_q == NEXT);
  assign req_done   = (state_q == DONE);
  assign req_rdata  = rdata_q;
  assign err        = err_q;
  assign err_code   = code_q;

  assign lram_addr  = idx_q;
  assign lram_wdata = cap_q;
  assign lram_we    = (state_q == NEXT) && (mode_q == MODE_BULK_RD) &&
                      resp_ok;

  assign avm_read   = (state_q == RD);
  assign avm_write  = (state_q == WR);
  assign avm_wdata  = wdata_q;
  assign avm_addr   = !strobe          ? '0 :
                      is_bulk(mode_q)  ? base_q + AW'(idx_q) :
                                         base_q;

endmodule
